// File: rtl/sram_loader_pkg.sv
// sram_loader_pkg
//   Shared definitions for the SRAM loader: default geometry, the loader
//   state encoding and a small state-classification helper.
//   The readback-verify states are always enumerated. They are only reachable
//   when the design is built with SRAM_LOADER_VERIFY_EN defined.
package sram_loader_pkg;

    localparam int SL_DATA_WIDTH = 32;
    localparam int SL_ADDR_WIDTH = 13;
    localparam int RAM_DEPTH     = 8192;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WRITE,
        ST_VERIFY_RD,
        ST_VERIFY_CMP,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

    // A load is in flight: start requests are ignored in these states.
    function automatic logic state_is_busy(input loader_state_t s);
        return (s == ST_COLLECT) || (s == ST_WRITE) ||
               (s == ST_VERIFY_RD) || (s == ST_VERIFY_CMP);
    endfunction

endpackage

// File: rtl/sram_loader_packer.sv
// sram_loader_packer
//   Assembles upstream bytes into SRAM words, little-endian: the first byte
//   of a word lands in bits [7:0].
//   Ports:
//     clk         rising-edge clock
//     srst        synchronous active-high reset (clears index and word)
//     clear       restart at byte lane 0 (new load); the word contents are kept
//     byte_accept byte transfers this cycle (valid && ready upstream)
//     byte_data   upstream byte
//     word        assembled word; held until the next word starts overwriting it
//     word_valid  combinational pulse: the final byte of a word is accepted now
module sram_loader_packer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  clear,
    input  logic                  byte_accept,
    input  logic [7:0]            byte_data,
    output logic [DATA_WIDTH-1:0] word,
    output logic                  word_valid
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [IDX_W-1:0] index_reg;
    logic             last_lane;

    assign last_lane  = (index_reg == IDX_W'(BYTES - 1));
    assign word_valid = byte_accept && last_lane;

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            index_reg <= '0;
        end else if (byte_accept) begin
            index_reg <= last_lane ? '0 : index_reg + IDX_W'(1);
        end
    end

    // One register per byte lane; a lane loads only when the index selects it.
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
        logic [7:0] lane_reg;

        always_ff @(posedge clk) begin
            if (srst) begin
                lane_reg <= '0;
            end else if (byte_accept && !clear && (index_reg == IDX_W'(gi))) begin
                lane_reg <= byte_data;
            end
        end

        assign word[gi*8 +: 8] = lane_reg;
    end

endmodule

// File: rtl/sram_loader.sv
// sram_loader
//   Streams bytes from an SPI/microSD source into a synchronous SRAM.
//   Bytes are packed into words and each word is written to BASE_ADDR + n,
//   with the address wrapping modulo 2^ADDR_WIDTH.
//   Optional build macro: SRAM_LOADER_VERIFY_EN. When it is defined, every
//   write is read back and compared. A mismatch stops the load in ERROR.
//   Ports:
//     loader_clk, loader_rst     clock, synchronous active-high reset
//     loader_start               one-cycle load request (idle/done/error only)
//     loader_word_count          words to load, 0 .. 2^ADDR_WIDTH
//     loader_byte_valid/_data    upstream byte stream
//     loader_byte_ready          high only while collecting bytes
//     loader_sram_address/_data  SRAM address and write data
//     loader_sram_cs/_we         SRAM chip select / write enable
//     loader_sram_q              SRAM read data, valid the cycle after a read
//     loader_busy/_done/_error   status levels
//     loader_words_written       words committed in the current/last load
module sram_loader
    import sram_loader_pkg::*;
#(
    parameter int DATA_WIDTH = SL_DATA_WIDTH,
    parameter int ADDR_WIDTH = SL_ADDR_WIDTH,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  loader_clk,
    input  logic                  loader_rst,
    input  logic                  loader_start,
    input  logic [ADDR_WIDTH:0]   loader_word_count,
    input  logic                  loader_byte_valid,
    input  logic [7:0]            loader_byte_data,
    output logic                  loader_byte_ready,
    output logic [ADDR_WIDTH-1:0] loader_sram_address,
    output logic [DATA_WIDTH-1:0] loader_sram_data,
    output logic                  loader_sram_cs,
    output logic                  loader_sram_we,
    input  logic [DATA_WIDTH-1:0] loader_sram_q,
    output logic                  loader_busy,
    output logic                  loader_done,
    output logic                  loader_error,
    output logic [ADDR_WIDTH:0]   loader_words_written
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0]      MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [CNT_W-1:0]      CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);

    loader_state_t state_reg, state_next;

    logic [CNT_W-1:0]      words_written_reg;
    logic [CNT_W-1:0]      target_reg;
    logic [ADDR_WIDTH-1:0] address_reg;
    logic                  ready_reg, cs_reg, we_reg;
    logic                  busy_reg, done_reg, error_reg;

    logic                  start_ok;
    logic                  byte_accept;
    logic                  word_valid;
    logic                  last_word;
    logic                  commit;
    logic [DATA_WIDTH-1:0] packed_word;

    assign byte_accept = loader_byte_valid && ready_reg;
    // The word being committed now is the final word of the load.
    assign last_word   = ((words_written_reg + CNT_ONE) == target_reg);

    sram_loader_packer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_packer (
        .clk         (loader_clk),
        .srst        (loader_rst),
        .clear       (start_ok),
        .byte_accept (byte_accept),
        .byte_data   (loader_byte_data),
        .word        (packed_word),
        .word_valid  (word_valid)
    );

`ifdef SRAM_LOADER_VERIFY_EN
    logic verify_ok;
    assign verify_ok = (loader_sram_q == packed_word);
    assign commit    = (state_reg == ST_VERIFY_CMP) && verify_ok;
`else
    logic unused_sram_q;
    assign unused_sram_q = ^loader_sram_q;
    assign commit        = (state_reg == ST_WRITE);
`endif

    always_comb begin
        state_next = state_reg;
        start_ok   = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (loader_start) begin
                    start_ok = 1'b1;
                    if (loader_word_count == '0) begin
                        state_next = ST_DONE;
                    end else if (loader_word_count > MAX_WORDS) begin
                        state_next = ST_ERROR;
                    end else begin
                        state_next = ST_COLLECT;
                    end
                end
            end
            ST_COLLECT: begin
                if (word_valid) begin
                    state_next = ST_WRITE;
                end
            end
`ifdef SRAM_LOADER_VERIFY_EN
            ST_WRITE:     state_next = ST_VERIFY_RD;
            ST_VERIFY_RD: state_next = ST_VERIFY_CMP;
            ST_VERIFY_CMP: begin
                if (!verify_ok) begin
                    state_next = ST_ERROR;
                end else begin
                    state_next = last_word ? ST_DONE : ST_COLLECT;
                end
            end
`else
            ST_WRITE: state_next = last_word ? ST_DONE : ST_COLLECT;
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    // State register plus outputs registered from the next state, so every
    // status/strobe output lines up with the state it describes.
    always_ff @(posedge loader_clk) begin
        if (loader_rst) begin
            state_reg         <= ST_IDLE;
            words_written_reg <= '0;
            target_reg        <= '0;
            address_reg       <= '0;
            ready_reg         <= 1'b0;
            cs_reg            <= 1'b0;
            we_reg            <= 1'b0;
            busy_reg          <= 1'b0;
            done_reg          <= 1'b0;
            error_reg         <= 1'b0;
        end else begin
            state_reg <= state_next;

            if (start_ok) begin
                words_written_reg <= '0;
                target_reg        <= loader_word_count;
            end else if (commit) begin
                words_written_reg <= words_written_reg + CNT_ONE;
            end

            // The committed count is the index of the word about to be written.
            if (state_next == ST_WRITE) begin
                address_reg <= BASE + words_written_reg[ADDR_WIDTH-1:0];
            end

            ready_reg <= (state_next == ST_COLLECT);
            cs_reg    <= (state_next == ST_WRITE) || (state_next == ST_VERIFY_RD);
            we_reg    <= (state_next == ST_WRITE);
            busy_reg  <= state_is_busy(state_next);
            done_reg  <= (state_next == ST_DONE);
            error_reg <= (state_next == ST_ERROR);
        end
    end

    assign loader_byte_ready    = ready_reg;
    assign loader_sram_address  = address_reg;
    assign loader_sram_data     = packed_word;
    assign loader_sram_cs       = cs_reg;
    assign loader_sram_we       = we_reg;
    assign loader_busy          = busy_reg;
    assign loader_done          = done_reg;
    assign loader_error         = error_reg;
    assign loader_words_written = words_written_reg;

endmodule
